// File: rtl/div_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : div_pkg                                                    |
// | Description : Shared types and constants for the sequential signed      |
// |               divider: FSM state encoding and default operand width.     |
// |               Optional feature macro used by the divider:                |
// |               SEQ_DIVIDER_DBZ_FLAG_EN (divide-by-zero fast path + flag). |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package div_pkg;

  // Default operand/result width of the divider.
  localparam int DIV_WIDTH_DEFAULT = 64;

  // Divider control states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,  // waiting for an operand pair
    DIVIDE = 2'd1,  // one restoring step per cycle
    FIXUP  = 2'd2,  // apply result signs
    DONE   = 2'd3   // result presented, waiting for consumer
  } div_state_t;

endpackage : div_pkg
`default_nettype wire

// File: rtl/div_restore_step.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : div_restore_step                                           |
// | Description : One combinational restoring-division step on unsigned      |
// |               magnitudes. Shifts {rem,quo} left by one, trial-subtracts  |
// |               the divisor magnitude and keeps or restores the result.    |
// | Ports       : rem         - partial remainder (WIDTH)                    |
// |               quo         - partial quotient / remaining dividend bits   |
// |               abs_divisor - divisor magnitude (WIDTH+1)                  |
// |               rem_next    - updated partial remainder                    |
// |               quo_next    - updated quotient, new bit in LSB             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module div_restore_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH:0]   abs_divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH-1:0] w_diff;
  logic             w_fits;

  // Bring the next dividend bit into the partial remainder.
  assign w_rem_sh = {rem, quo[WIDTH-1]};

  // Non-negative trial difference <=> shifted remainder >= divisor.
  assign w_fits = (w_rem_sh >= abs_divisor);

  // When the subtraction succeeds the true difference is below the divisor
  // magnitude (at most 2^(WIDTH-1)), so WIDTH-bit arithmetic is exact.
  assign w_diff = w_rem_sh[WIDTH-1:0] - abs_divisor[WIDTH-1:0];

  // On restore the shifted remainder is below the divisor, so its top bit is 0.
  assign rem_next = w_fits ? w_diff : w_rem_sh[WIDTH-1:0];
  assign quo_next = {quo[WIDTH-2:0], w_fits};

endmodule : div_restore_step
`default_nettype wire

// File: rtl/seq_signed_divider.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : seq_signed_divider                                         |
// | Description : Sequential signed two's-complement divider, one restoring  |
// |               step per clock. Truncates toward zero; remainder carries   |
// |               the dividend's sign. MIN/-1 wraps to MIN rem 0; divisor 0  |
// |               gives quotient -1 and remainder = dividend.                |
// | Ports       : clk, rst (async, active-high)                              |
// |               in_valid/in_ready, dividend, divisor  - operand handshake  |
// |               out_valid/out_ready, quotient, remainder - result handshake|
// |               div_by_zero (only with SEQ_DIVIDER_DBZ_FLAG_EN)            |
// | Macro       : SEQ_DIVIDER_DBZ_FLAG_EN - adds div_by_zero flag and lets a |
// |               zero divisor bypass DIVIDE/FIXUP (IDLE -> DONE).           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module seq_signed_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
`ifdef SEQ_DIVIDER_DBZ_FLAG_EN
  ,
  output logic             div_by_zero
`endif
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_t       r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH:0]   r_abs_dvs;
  logic             r_dvd_neg;
  logic             r_dvs_neg;
  logic             r_dvs_zero;
`ifdef SEQ_DIVIDER_DBZ_FLAG_EN
  logic             r_div_by_zero;
`endif

  logic             w_dvd_neg;
  logic             w_dvs_neg;
  logic             w_dvs_zero;
  logic [WIDTH:0]   w_dvd_ext;
  logic [WIDTH:0]   w_dvs_ext;
  logic [WIDTH-1:0] w_abs_dvd;
  logic [WIDTH:0]   w_abs_dvs;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quo_next;

  // Magnitudes are formed in WIDTH+1 bits so the most-negative operand is
  // exact. |dividend| never exceeds 2^(WIDTH-1), so it fits WIDTH unsigned bits.
  assign w_dvd_neg  = dividend[WIDTH-1];
  assign w_dvs_neg  = divisor[WIDTH-1];
  assign w_dvs_zero = (divisor == '0);
  assign w_dvd_ext  = {dividend[WIDTH-1], dividend};
  assign w_dvs_ext  = {divisor[WIDTH-1], divisor};
  assign w_abs_dvd  = w_dvd_neg ? WIDTH'(-w_dvd_ext) : w_dvd_ext[WIDTH-1:0];
  assign w_abs_dvs  = w_dvs_neg ? -w_dvs_ext : w_dvs_ext;

  div_restore_step #(
    .WIDTH       (WIDTH)
  ) u_step (
    .rem         (r_rem),
    .quo         (r_quo),
    .abs_divisor (r_abs_dvs),
    .rem_next    (w_rem_next),
    .quo_next    (w_quo_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_in_ready    <= 1'b1;
      r_out_valid   <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_count       <= '0;
      r_rem         <= '0;
      r_quo         <= '0;
      r_abs_dvs     <= '0;
      r_dvd_neg     <= 1'b0;
      r_dvs_neg     <= 1'b0;
      r_dvs_zero    <= 1'b0;
`ifdef SEQ_DIVIDER_DBZ_FLAG_EN
      r_div_by_zero <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          // in_ready is high exactly in IDLE, so in_valid alone marks a transfer.
          if (in_valid) begin
            r_rem      <= '0;
            r_quo      <= w_abs_dvd;
            r_abs_dvs  <= w_abs_dvs;
            r_dvd_neg  <= w_dvd_neg;
            r_dvs_neg  <= w_dvs_neg;
            r_dvs_zero <= w_dvs_zero;
            r_count    <= CNT_W'(WIDTH - 1);
            r_in_ready <= 1'b0;
`ifdef SEQ_DIVIDER_DBZ_FLAG_EN
            if (w_dvs_zero) begin
              // Result is known immediately; skip the iterative path.
              r_quotient    <= '1;
              r_remainder   <= dividend;
              r_div_by_zero <= 1'b1;
              r_out_valid   <= 1'b1;
              r_state       <= DONE;
            end else begin
              r_state <= DIVIDE;
            end
`else
            r_state <= DIVIDE;
`endif
          end
        end

        DIVIDE: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          if (r_count == '0) begin
            r_state <= FIXUP;
          end else begin
            r_count <= r_count - 1'b1;
          end
        end

        FIXUP: begin
          // A zero divisor yields all-ones magnitude; keep it as -1 regardless
          // of the dividend sign. MIN/-1 wraps naturally through the negation.
          if ((r_dvd_neg ^ r_dvs_neg) && !r_dvs_zero) begin
            r_quotient <= -r_quo;
          end else begin
            r_quotient <= r_quo;
          end
          r_remainder <= r_dvd_neg ? -r_rem : r_rem;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end

        DONE: begin
          if (out_ready) begin
            r_out_valid   <= 1'b0;
            r_in_ready    <= 1'b1;
`ifdef SEQ_DIVIDER_DBZ_FLAG_EN
            r_div_by_zero <= 1'b0;
`endif
            r_state       <= IDLE;
          end
        end

        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign quotient  = r_quotient;
  assign remainder = r_remainder;
`ifdef SEQ_DIVIDER_DBZ_FLAG_EN
  assign div_by_zero = r_div_by_zero;
`endif

endmodule : seq_signed_divider
`default_nettype wire

// File: tb/tb_seq_signed_divider.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_seq_signed_divider                                      |
// | Description : Self-checking bench for seq_signed_divider (WIDTH=64).     |
// |               Expected results are queued when operands are driven and   |
// |               popped when the DUT presents out_valid. Latency is counted |
// |               in rising edges from the transfer edge (inclusive) to the  |
// |               edge after which out_valid is high.                        |
// |               Honours SEQ_DIVIDER_DBZ_FLAG_EN.                           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_seq_signed_divider;

  localparam int W = 64;
  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};
`ifdef SEQ_DIVIDER_DBZ_FLAG_EN
  localparam int DBZ_LAT = 1;
`else
  localparam int DBZ_LAT = W + 2;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
`ifdef SEQ_DIVIDER_DBZ_FLAG_EN
  logic         div_by_zero;
`endif

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q_fifo[$];
  logic [W-1:0] exp_r_fifo[$];
  int           exp_l_fifo[$];

  seq_signed_divider #(
    .WIDTH       (W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder)
`ifdef SEQ_DIVIDER_DBZ_FLAG_EN
    ,
    .div_by_zero (div_by_zero)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference division (truncate toward zero, remainder follows dividend).
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r);
    longint sa, sb;
    sa = longint'(a);
    sb = longint'(b);
    if (sb == 0) begin
      q = '1;
      r = a;
    end else if (a == MINV && sb == -1) begin
      q = MINV;
      r = '0;
    end else begin
      q = W'(sa / sb);
      r = W'(sa % sb);
    end
  endtask

  // Drive one operand pair, wait for the result, compare against the
  // scoreboard, optionally stall the consumer, then accept the result.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input int elat, input int hold);
    int n;
    int lat;
    int unstable;
    logic [W-1:0] pq, pr, sq, sr;
    int pl;
    exp_q_fifo.push_back(eq);
    exp_r_fifo.push_back(er);
    exp_l_fifo.push_back(elat);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 4 * W) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_in_ready"}, W'(in_ready), W'(1));
    @(posedge clk); #1;
    // Garbage operands with in_valid held high must be ignored while busy.
    dividend = {$urandom, $urandom};
    divisor  = {$urandom, $urandom};
    lat = 1;
    while (out_valid !== 1'b1 && lat < 4 * W) begin
      @(posedge clk); #1; lat++;
    end
    in_valid = 1'b0;
    pq = exp_q_fifo.pop_front();
    pr = exp_r_fifo.pop_front();
    pl = exp_l_fifo.pop_front();
    chk({tag, "_quotient"}, quotient, pq);
    chk({tag, "_remainder"}, remainder, pr);
    chk({tag, "_latency"}, W'(lat), W'(pl));
    chk({tag, "_busy_in_ready"}, W'(in_ready), W'(0));
`ifdef SEQ_DIVIDER_DBZ_FLAG_EN
    chk({tag, "_dbz"}, W'(div_by_zero), W'(b == '0));
`endif
    if (hold > 0) begin
      sq = quotient;
      sr = remainder;
      unstable = 0;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        if (quotient !== sq || remainder !== sr || out_valid !== 1'b1 || in_ready !== 1'b0)
          unstable++;
      end
      chk({tag, "_hold_stable"}, W'(unstable), W'(0));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_ack_out_valid"}, W'(out_valid), W'(0));
    chk({tag, "_ack_in_ready"}, W'(in_ready), W'(1));
  endtask

  initial begin
    logic [W-1:0] ra, rb, mq, mr;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", W'(in_ready), W'(1));
    chk("reset_out_valid", W'(out_valid), W'(0));
    chk("reset_quotient", quotient, '0);
    chk("reset_remainder", remainder, '0);
    #3 rst = 1'b0;

    // Basic sign combinations; the first also stalls the consumer 10 cycles.
    run_op("p100_p7", 64'sd100, 64'sd7, 64'sd14, 64'sd2, W + 2, 10);
    run_op("n100_p7", -64'sd100, 64'sd7, -64'sd14, -64'sd2, W + 2, 0);
    run_op("p100_n7", 64'sd100, -64'sd7, -64'sd14, 64'sd2, W + 2, 0);
    run_op("n100_n7", -64'sd100, -64'sd7, 64'sd14, -64'sd2, W + 2, 0);

    // Boundary cases.
    run_op("min_by_m1", MINV, -64'sd1, MINV, 64'd0, W + 2, 0);
    run_op("p123_by_0", 64'sd123, 64'd0, {W{1'b1}}, 64'sd123, DBZ_LAT, 0);
    run_op("n123_by_0", -64'sd123, 64'd0, {W{1'b1}}, -64'sd123, DBZ_LAT, 0);
    run_op("min_by_p1", MINV, 64'sd1, MINV, 64'd0, W + 2, 0);
    run_op("small_by_big", 64'sd5, -64'sd9, 64'd0, 64'sd5, W + 2, 0);

    // A few random operand pairs checked against the reference model.
    for (int k = 0; k < 3; k++) begin
      ra = {$urandom, $urandom};
      rb = {{32{1'b0}}, $urandom} ^ {W{k[0]}};
      if (rb == '0) rb = 64'd3;
      model(ra, rb, mq, mr);
      run_op($sformatf("rand%0d", k), ra, rb, mq, mr, W + 2, 0);
    end

    // Abort an operation at step 30 of DIVIDE with an asynchronous reset.
    dividend = 64'sd1000;
    divisor  = 64'sd3;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (30) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", W'(out_valid), W'(0));
    chk("midrst_in_ready", W'(in_ready), W'(1));
    chk("midrst_quotient", quotient, '0);
    chk("midrst_remainder", remainder, '0);
    #3 rst = 1'b0;
    run_op("after_rst_50_5", 64'sd50, 64'sd5, 64'sd10, 64'd0, W + 2, 0);

    chk("scoreboard_empty", W'(exp_q_fifo.size()), W'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_seq_signed_divider
`default_nettype wire
